// File: rtl/ks_sub_pipe_16b.sv
// Pipelined 16-bit Kogge-Stone subtractor D = X - Y, evaluated as X + ~Y + 1; 3-cycle latency.
// Optional macro KS_SUB_SATURATE_EN clamps negative results to zero.
module ks_sub_pipe_16b #(
   parameter int WIDTH     = 16,
   parameter bit ZERO_FLAG = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] D,
   output logic             out_borrow,
   output logic             out_zero
);

   logic             adv;
   logic [WIDTH-1:0] p0, g0;
   logic [WIDTH-1:0] p1, g1;
   logic [WIDTH-1:0] ga, pa, gb, pb;
   logic [WIDTH-1:0] p2, g2, p0_2;
   logic [WIDTH-1:0] gc, pc, gd;
   logic [WIDTH-1:0] d_raw, d_next;
   logic             v1, v2;
   logic             borrow_next, zero_next;

   assign adv      = !out_valid | out_ready;
   assign in_ready = adv;

   // Carry-in of 1 folded into bit 0 so the prefix tree needs no separate cin.
   always_comb begin
      p0    = X ^ ~Y;
      g0    = X & ~Y;
      g0[0] = g0[0] | p0[0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1 <= 1'b0;
         p1 <= '0;
         g1 <= '0;
      end else if (adv) begin
         v1 <= in_valid;
         p1 <= p0;
         g1 <= g0;
      end
   end

   always_comb begin
      ga = g1;
      pa = p1;
      for (int unsigned i = 1; i < WIDTH; i++) begin
         ga[i] = g1[i] | (g1[i-1] & p1[i]);
         pa[i] = p1[i] & p1[i-1];
      end
   end

   always_comb begin
      gb = ga;
      pb = pa;
      for (int unsigned i = 2; i < WIDTH; i++) begin
         gb[i] = ga[i] | (ga[i-2] & pa[i]);
         pb[i] = pa[i] & pa[i-2];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2   <= 1'b0;
         g2   <= '0;
         p2   <= '0;
         p0_2 <= '0;
      end else if (adv) begin
         v2   <= v1;
         g2   <= gb;
         p2   <= pb;
         p0_2 <= p1;
      end
   end

   always_comb begin
      gc = g2;
      pc = p2;
      for (int unsigned i = 4; i < WIDTH; i++) begin
         gc[i] = g2[i] | (g2[i-4] & p2[i]);
         pc[i] = p2[i] & p2[i-4];
      end
   end

   // Last level only needs generate; group propagate is no longer consumed.
   always_comb begin
      gd = gc;
      for (int unsigned i = 8; i < WIDTH; i++) begin
         gd[i] = gc[i] | (gc[i-8] & pc[i]);
      end
   end

   always_comb begin
      d_raw[0] = ~p0_2[0];
      for (int unsigned i = 1; i < WIDTH; i++) begin
         d_raw[i] = p0_2[i] ^ gd[i-1];
      end
      borrow_next = ~gd[WIDTH-1];
`ifdef KS_SUB_SATURATE_EN
      d_next = borrow_next ? '0 : d_raw;
`else
      d_next = d_raw;
`endif
      zero_next = ZERO_FLAG ? (d_next == '0) : 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         D          <= '0;
         out_borrow <= 1'b0;
         out_zero   <= 1'b0;
      end else if (adv) begin
         out_valid  <= v2;
         D          <= d_next;
         out_borrow <= borrow_next;
         out_zero   <= zero_next;
      end
   end

endmodule

// File: tb/tb_ks_sub_pipe_16b.sv
// Self-checking bench for ks_sub_pipe_16b: queue-based reference model plus directed literal vectors.
module tb_ks_sub_pipe_16b;

   typedef struct packed {
      logic [15:0] d;
      logic        b;
      logic        z;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] X = '0;
   logic [15:0] Y = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] D;
   logic        out_borrow;
   logic        out_zero;

   int   checks = 0;
   int   errors = 0;
   int   out_xfers = 0;
   exp_t q[$];

   ks_sub_pipe_16b #(.WIDTH(16), .ZERO_FLAG(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .X(X), .Y(Y), .out_valid(out_valid), .out_ready(out_ready),
      .D(D), .out_borrow(out_borrow), .out_zero(out_zero)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [15:0] x, input logic [15:0] y);
      exp_t        e;
      int unsigned diff;
      diff = (int'(x) + 65536 - int'(y)) % 65536;
      e.b  = (x < y);
      e.d  = diff[15:0];
`ifdef KS_SUB_SATURATE_EN
      if (e.b) e.d = 16'h0000;
`endif
      e.z  = (e.d == 16'h0000);
      return e;
   endfunction

   // Reference scoreboard: every cycle out_valid is high must match the oldest accepted operand.
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
      end else begin
         checks++;
         if (in_ready !== (!out_valid || out_ready)) begin
            errors++;
            $display("FAIL in_ready: got %b want %b", in_ready, !out_valid || out_ready);
         end
         if (out_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL spurious_out: D=%h with no operand outstanding", D);
            end else begin
               if ({D, out_borrow, out_zero} !== q[0]) begin
                  errors++;
                  $display("FAIL model_cmp: got D=%h b=%b z=%b want D=%h b=%b z=%b",
                           D, out_borrow, out_zero, q[0].d, q[0].b, q[0].z);
               end
               if (out_ready) begin
                  void'(q.pop_front());
                  out_xfers++;
               end
            end
         end
         if (in_valid && in_ready) q.push_back(model(X, Y));
      end
   end

   task automatic lit(input logic [15:0] x, input logic [15:0] y,
                      input logic [15:0] ed, input logic eb, input logic ez);
      logic [15:0] d_e;
      logic        z_e;
      int          k;
      d_e = ed;
      z_e = ez;
`ifdef KS_SUB_SATURATE_EN
      if (eb) begin
         d_e = 16'h0000;
         z_e = 1'b1;
      end
`endif
      checks++;
      if (model(x, y) !== {d_e, eb, z_e}) begin
         errors++;
         $display("FAIL model_pin %h-%h: got %h want %h", x, y, model(x, y), {d_e, eb, z_e});
      end
      @(posedge clk); #1;
      X = x; Y = y; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      k = 0;
      for (int c = 1; c <= 8 && k == 0; c++) begin
         @(negedge clk);
         if (out_valid === 1'b1) k = c;
      end
      checks++;
      if (k != 3) begin
         errors++;
         $display("FAIL latency %h-%h: got %0d want 3", x, y, k);
      end
      checks++;
      if ({D, out_borrow, out_zero} !== {d_e, eb, z_e}) begin
         errors++;
         $display("FAIL lit %h-%h: got D=%h b=%b z=%b want D=%h b=%b z=%b",
                  x, y, D, out_borrow, out_zero, d_e, eb, z_e);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL pulse %h-%h: out_valid got %b want 0", x, y, out_valid);
      end
   endtask

   task automatic drain;
      int n;
      n = 0;
      out_ready = 1'b1;
      in_valid  = 1'b0;
      while ((q.size() != 0 || out_valid === 1'b1) && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (q.size() != 0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain_timeout: queue %0d out_valid %b want 0 0", q.size(), out_valid);
      end
   endtask

   initial begin
      int base;
      #3;
      checks++;
      if ({out_valid, D, out_borrow, out_zero, in_ready} !== {1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_state: got v=%b D=%h b=%b z=%b ir=%b want 0 0000 0 0 1",
                  out_valid, D, out_borrow, out_zero, in_ready);
      end
      @(negedge clk); #2;
      rst = 1'b0;

      lit(16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0);
      lit(16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
      lit(16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b1);
      lit(16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0);
      lit(16'h0000, 16'hFFFF, 16'h0001, 1'b1, 1'b0);
      lit(16'hA5A5, 16'h0000, 16'hA5A5, 1'b0, 1'b0);
      lit(16'h7FFF, 16'h7FFF, 16'h0000, 1'b0, 1'b1);

      // Streaming: 8 back-to-back operands.
      base = out_xfers;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         X = 16'h1111 * 16'(i + 1); Y = 16'h0101 * 16'(i * 3); in_valid = 1'b1;
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_ready %0d: got %b want 1", i, in_ready);
         end
      end
      @(posedge clk); #1;
      drain();
      checks++;
      if (out_xfers - base != 8) begin
         errors++;
         $display("FAIL stream_count: got %0d want 8", out_xfers - base);
      end

      // Back-pressure: 3 ops in flight, output stalled 5 cycles, a 4th op offered throughout.
      base = out_xfers;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         X = 16'h0300 + 16'(i); Y = 16'h0400 - 16'(i); in_valid = 1'b1;
      end
      @(posedge clk); #1;
      X = 16'h4444; Y = 16'h1111; in_valid = 1'b1; out_ready = 1'b0;
      for (int i = 0; i < 5; i++) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_ready: got %b want 0", in_ready);
      end
      out_ready = 1'b1;
      while (!in_ready) @(negedge clk);
      @(posedge clk); #1;
      drain();
      checks++;
      if (out_xfers - base != 4) begin
         errors++;
         $display("FAIL bp_count: got %0d want 4", out_xfers - base);
      end

      // Random sweep with random valid and ready.
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         X = 16'($urandom); Y = 16'($urandom);
         if (i % 5 == 0) Y = X;
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(3) != 0);
      end
      @(posedge clk); #1;
      drain();

      // Reset with operands in flight.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         X = 16'h9000 + 16'(i); Y = 16'h0001; in_valid = 1'b1;
      end
      in_valid = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if ({out_valid, D, out_borrow, out_zero, in_ready} !== {1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL async_reset: got v=%b D=%h b=%b z=%b ir=%b want 0 0000 0 0 1",
                  out_valid, D, out_borrow, out_zero, in_ready);
      end
      @(negedge clk); #2;
      rst = 1'b0;
      lit(16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
